// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer_pkg
// Description : Store/load codes and default depth shared by the store buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package store_buffer_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_SW  = 2'b00,
        ST_SH  = 2'b01,
        ST_SB  = 2'b10,
        ST_RSV = 2'b11
    } store_t;

    // Consumed by the downstream load-extension logic, not by the buffer.
    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_t;

    function automatic store_t norm_store(input logic [1:0] code);
        return (code == 2'b11) ? ST_SW : store_t'(code);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : sb_fwd_match
// Description : Youngest-match priority search over the store buffer entries.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic [PW-1:0]             i_rd_ptr,
    input  logic [CW-1:0]             i_count,
    input  logic [29:0]               i_ld_word,
    input  logic [DEPTH-1:0][29:0]    i_entry_word,
    input  store_t [DEPTH-1:0]        i_entry_type,
    output logic                      o_hit,
    output logic [PW-1:0]             o_hit_idx,
    output store_t                    o_hit_type
);

    // Walk from oldest to youngest; a later match overwrites an earlier one.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_idx  = '0;
        o_hit_type = ST_SW;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < i_count) &&
                (i_entry_word[i_rd_ptr + PW'(k)] == i_ld_word)) begin
                o_hit      = 1'b1;
                o_hit_idx  = i_rd_ptr + PW'(k);
                o_hit_type = i_entry_type[i_rd_ptr + PW'(k)];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Posted-write FIFO in front of the data memory with load forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    input  logic [1:0]                 st_type,
    output logic                       st_ready,
    input  logic                       drain_en,
    output logic                       mem_we,
    output logic [31:0]                mem_WA,
    output logic [31:0]                mem_WD,
    output logic [1:0]                 store,
    input  logic                       ld_valid,
    input  logic [31:0]                ld_addr,
    output logic                       ld_hit,
    output logic [31:0]                ld_fwd_data,
    output logic                       ld_stall,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_wr_ptr;
    logic [CW-1:0]          r_count;
    logic [DEPTH-1:0][31:0] r_addr;
    logic [DEPTH-1:0][31:0] r_data;
    store_t [DEPTH-1:0]     r_type;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_enq;
    logic                   w_deq;
    logic [DEPTH-1:0][29:0] w_word;
    logic                   w_hit;
    logic [PW-1:0]          w_hit_idx;
    store_t                 w_hit_type;
    logic                   w_fwd_ok;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_enq   = st_valid && !w_full;
    assign w_deq   = !w_empty && drain_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload is qualified by the pointers, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_wr_ptr] <= st_addr;
            r_data[r_wr_ptr] <= st_data;
            r_type[r_wr_ptr] <= norm_store(st_type);
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_word
            assign w_word[g] = r_addr[g][31:2];
        end
    endgenerate

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .CW    (CW)
    ) u_fwd_match (
        .i_rd_ptr     (r_rd_ptr),
        .i_count      (r_count),
        .i_ld_word    (ld_addr[31:2]),
        .i_entry_word (w_word),
        .i_entry_type (r_type),
        .o_hit        (w_hit),
        .o_hit_idx    (w_hit_idx),
        .o_hit_type   (w_hit_type)
    );

    // Only a full-word store can satisfy an aligned load; anything else waits.
    assign w_fwd_ok    = ld_valid && w_hit && (w_hit_type == ST_SW) && (ld_addr[1:0] == 2'b00);
    assign ld_hit      = w_fwd_ok;
    assign ld_stall    = ld_valid && w_hit && !w_fwd_ok;
    assign ld_fwd_data = w_fwd_ok ? r_data[w_hit_idx] : '0;

    assign st_ready = !w_full;
    assign mem_we   = w_deq;
    assign mem_WA   = r_addr[r_rd_ptr];
    assign mem_WD   = r_data[r_rd_ptr];
    assign store    = r_type[r_rd_ptr];
    assign count    = r_count;
    assign empty    = w_empty;
    assign full     = w_full;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Directed and randomized check of store_buffer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          st_valid;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic [1:0]    st_type;
    logic          st_ready;
    logic          drain_en;
    logic          mem_we;
    logic [31:0]   mem_WA;
    logic [31:0]   mem_WD;
    logic [1:0]    store;
    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic          ld_hit;
    logic [31:0]   ld_fwd_data;
    logic          ld_stall;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_type     (st_type),
        .st_ready    (st_ready),
        .drain_en    (drain_en),
        .mem_we      (mem_we),
        .mem_WA      (mem_WA),
        .mem_WD      (mem_WD),
        .store       (store),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_hit      (ld_hit),
        .ld_fwd_data (ld_fwd_data),
        .ld_stall    (ld_stall),
        .count       (count),
        .empty       (empty),
        .full        (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  code;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_fwd(output logic hit, output logic stall, output logic [31:0] data);
        hit = 1'b0; stall = 1'b0; data = '0;
        if (ld_valid) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].addr[31:2] == ld_addr[31:2]) begin
                    if (q[i].code == 2'b00 && ld_addr[1:0] == 2'b00) begin
                        hit  = 1'b1;
                        data = q[i].data;
                    end else begin
                        stall = 1'b1;
                    end
                    break;
                end
            end
        end
    endtask

    task automatic check_all();
        logic        e_hit, e_stall;
        logic [31:0] e_data;
        check("count",    32'(count),    q.size());
        check("empty",    32'(empty),    32'(q.size() == 0));
        check("full",     32'(full),     32'(q.size() == DEPTH));
        check("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
        check("mem_we",   32'(mem_we),   32'(q.size() > 0 && drain_en));
        if (q.size() > 0) begin
            check("mem_WA", mem_WA,      q[0].addr);
            check("mem_WD", mem_WD,      q[0].data);
            check("store",  32'(store),  32'(q[0].code));
        end
        model_fwd(e_hit, e_stall, e_data);
        check("ld_hit",   32'(ld_hit),   32'(e_hit));
        check("ld_stall", 32'(ld_stall), 32'(e_stall));
        if (e_hit) check("ld_fwd_data", ld_fwd_data, e_data);
    endtask

    task automatic sample();
        @(negedge clk);
        check_all();
    endtask

    task automatic advance();
        bit deq, enq;
        @(posedge clk);
        deq = (q.size() > 0) && drain_en;
        enq = st_valid && (q.size() < DEPTH);
        if (deq) void'(q.pop_front());
        if (enq) q.push_back('{addr: st_addr, data: st_data,
                               code: (st_type == 2'b11) ? 2'b00 : st_type});
        #1;
    endtask

    task automatic idle();
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_type = 2'b00;
        drain_en = 1'b0; ld_valid = 1'b0; ld_addr = '0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        st_valid = 1'b1; st_addr = a; st_data = d; st_type = t;
        sample();
        advance();
        st_valid = 1'b0;
    endtask

    initial begin
        idle();
        rst_n    = 1'b0;
        drain_en = 1'b1;
        #12;
        check("rst_count",    32'(count),    32'd0);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_mem_we",   32'(mem_we),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) begin sample(); advance(); end

        // single store then drain
        push(32'h100, 32'hDEADBEEF, 2'b00);
        @(negedge clk);
        check("single_we", 32'(mem_we), 32'd1);
        check("single_WA", mem_WA,       32'h100);
        check("single_WD", mem_WD,       32'hDEADBEEF);
        check("single_st", 32'(store),   32'd0);
        check_all();
        advance();
        sample();
        check("single_empty", 32'(empty), 32'd1);
        advance();

        // fill to full, overflow attempt, ordered drain
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) push(32'(4 * i), 32'hA000_0000 + 32'(i), 2'b00);
        st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hBAD0BAD0;
        sample();
        check("full_flag",  32'(full),     32'd1);
        check("full_ready", 32'(st_ready), 32'd0);
        advance();
        st_valid = 1'b0;
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("drain_WA", mem_WA, 32'(4 * i));
            advance();
        end
        sample();
        check("drain_done", 32'(empty), 32'd1);
        advance();

        // youngest SW wins
        drain_en = 1'b0;
        push(32'h200, 32'h11111111, 2'b00);
        push(32'h200, 32'h22222222, 2'b00);
        ld_valid = 1'b1; ld_addr = 32'h200;
        sample();
        check("fwd_hit",  32'(ld_hit), 32'd1);
        check("fwd_data", ld_fwd_data, 32'h22222222);
        advance();
        ld_valid = 1'b0; drain_en = 1'b1;
        repeat (2) begin sample(); advance(); end

        // byte store blocks a word load until drained
        drain_en = 1'b0;
        push(32'h301, 32'h000000AB, 2'b10);
        ld_valid = 1'b1; ld_addr = 32'h300;
        sample();
        check("part_stall", 32'(ld_stall), 32'd1);
        advance();
        drain_en = 1'b1;
        sample();
        advance();
        sample();
        check("part_clear", 32'(ld_stall), 32'd0);
        advance();
        idle();

        // asynchronous reset with stores pending
        for (int i = 0; i < 3; i++) push(32'h400 + 32'(4 * i), $urandom, 2'b00);
        drain_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count",  32'(count),  32'd0);
        check("arst_mem_we", 32'(mem_we), 32'd0);
        check("arst_empty",  32'(empty),  32'd1);
        q.delete();
        rst_n = 1'b1;
        repeat (3) begin sample(); advance(); end

        // randomized traffic over a small address window
        for (int n = 0; n < 600; n++) begin
            st_valid = ($urandom_range(0, 99) < 60);
            st_addr  = 32'h200 + 32'($urandom_range(0, 31));
            st_data  = $urandom;
            st_type  = 2'($urandom_range(0, 3));
            drain_en = ($urandom_range(0, 99) < 45);
            ld_valid = ($urandom_range(0, 99) < 75);
            ld_addr  = 32'h200 + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) ld_addr[1:0] = 2'b00;
            sample();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
